// File: rtl/adapter_ppfifo_2_axi_stream_mc.sv
// Drains several ping-pong FIFO read ports onto one AXI Stream master.
// Channels are granted round-robin at block boundaries; a frame that spans
// blocks locks the grant to its channel until the frame's TLAST is pushed.
// Beats pass through a 2-entry skid buffer whose head drives the outputs,
// so the strobe never depends combinationally on i_axi_ready.
module adapter_ppfifo_2_axi_stream_mc #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STROBE_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 4,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned CHANNEL_BITS = 1
) (
  input  logic                                      i_axi_clk,
  input  logic                                      rst,
  input  logic [CHANNELS-1:0]                       i_ppfifo_rdy,
  output logic [CHANNELS-1:0]                       o_ppfifo_act,
  input  logic [CHANNELS*24-1:0]                    i_ppfifo_size,
  input  logic [CHANNELS*(DATA_WIDTH+USER_WIDTH)-1:0] i_ppfifo_data,
  output logic [CHANNELS-1:0]                       o_ppfifo_stb,
  input  logic [23:0]                               i_total_out_size,
  input  logic [STROBE_WIDTH-1:0]                   i_last_keep,
  output logic                                      o_axi_valid,
  input  logic                                      i_axi_ready,
  output logic [DATA_WIDTH-1:0]                     o_axi_data,
  output logic [STROBE_WIDTH-1:0]                   o_axi_keep,
  output logic                                      o_axi_last,
  output logic [USER_WIDTH-1:0]                     o_axi_user,
  output logic [CHANNEL_BITS-1:0]                   o_axi_dest
);

  localparam int unsigned WordWidth = DATA_WIDTH + USER_WIDTH;

  typedef enum logic [1:0] {StIdle, StStream, StRelease} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [USER_WIDTH-1:0]   user;
    logic [STROBE_WIDTH-1:0] keep;
    logic                    last;
    logic [CHANNEL_BITS-1:0] dest;
  } beat_t;

  state_e                  state_q, state_d;
  logic [CHANNELS-1:0]     act_q, act_d;
  logic [23:0]             size_q, size_d;
  logic [23:0]             count_q, count_d;
  logic [23:0]             frame_count_q, frame_count_d;
  logic [23:0]             frame_len_q, frame_len_d;
  logic [CHANNEL_BITS-1:0] last_grant_q, last_grant_d;
  logic [1:0]              occ_q, occ_d;
  beat_t                   ent0_q, ent0_d, ent1_q, ent1_d;

  logic                    grant_ok;
  logic [CHANNEL_BITS-1:0] grant_ch;
  logic [CHANNEL_BITS-1:0] cand;
  logic [WordWidth-1:0]    cur_word;
  logic                    stb_en;
  logic                    is_last;
  logic                    pop;
  beat_t                   push_beat;

  // Arbitration: locked frames wait on their own channel, otherwise round-robin.
  always_comb begin
    grant_ok = 1'b0;
    grant_ch = '0;
    cand     = '0;
    if (frame_count_q != 24'd0) begin
      grant_ok = i_ppfifo_rdy[last_grant_q] & ~act_q[last_grant_q];
      grant_ch = last_grant_q;
    end else begin
      // Walk from farthest to nearest so the nearest ready channel wins.
      for (int unsigned i = CHANNELS; i >= 1; i--) begin
        cand = CHANNEL_BITS'((32'(last_grant_q) + i) % CHANNELS);
        if (i_ppfifo_rdy[cand] && !act_q[cand]) begin
          grant_ok = 1'b1;
          grant_ch = cand;
        end
      end
    end
  end

  // Pop strobe and the beat it pushes into the skid buffer.
  always_comb begin
    cur_word = i_ppfifo_data[32'(last_grant_q) * WordWidth +: WordWidth];
    stb_en   = (state_q == StStream) && act_q[last_grant_q] &&
               ({1'b0, count_q} < {1'b0, size_q}) && (occ_q < 2'd2);
    if (frame_len_q == 24'd0) begin
      is_last = ({1'b0, count_q} + 25'd1) == {1'b0, size_q};
    end else begin
      is_last = ({1'b0, frame_count_q} + 25'd1) == {1'b0, frame_len_q};
    end
    push_beat.data = cur_word[DATA_WIDTH-1:0];
    push_beat.user = cur_word[WordWidth-1:DATA_WIDTH];
    push_beat.keep = is_last ? i_last_keep : '1;
    push_beat.last = is_last;
    push_beat.dest = last_grant_q;
    o_ppfifo_stb = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      o_ppfifo_stb[c] = stb_en && (last_grant_q == CHANNEL_BITS'(c));
    end
  end

  // Channel FSM next state: grant, stream a block, release the activate.
  always_comb begin
    state_d       = state_q;
    act_d         = act_q;
    size_d        = size_q;
    count_d       = count_q;
    frame_count_d = frame_count_q;
    frame_len_d   = frame_len_q;
    last_grant_d  = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          act_d           = '0;
          act_d[grant_ch] = 1'b1;
          size_d          = i_ppfifo_size[32'(grant_ch) * 24 +: 24];
          count_d         = 24'd0;
          last_grant_d    = grant_ch;
          if (frame_count_q == 24'd0) frame_len_d = i_total_out_size;
          state_d         = StStream;
        end
      end
      StStream: begin
        if (stb_en) begin
          count_d       = count_q + 24'd1;
          frame_count_d = is_last ? 24'd0 : frame_count_q + 24'd1;
        end else if (count_q == size_q) begin
          act_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Skid buffer next state: entry 0 is the head presented on the AXI outputs.
  always_comb begin
    pop    = (occ_q != 2'd0) && i_axi_ready;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({stb_en, pop})
      // Push and pop together only happen at occupancy 1.
      2'b11: ent0_d = push_beat;
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_beat;
        else               ent1_d = push_beat;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_axi_clk) begin
    if (rst) begin
      state_q       <= StIdle;
      act_q         <= '0;
      size_q        <= 24'd0;
      count_q       <= 24'd0;
      frame_count_q <= 24'd0;
      frame_len_q   <= 24'd0;
      last_grant_q  <= CHANNEL_BITS'(CHANNELS - 1);
      occ_q         <= 2'd0;
      ent0_q        <= '0;
      ent1_q        <= '0;
    end else begin
      state_q       <= state_d;
      act_q         <= act_d;
      size_q        <= size_d;
      count_q       <= count_d;
      frame_count_q <= frame_count_d;
      frame_len_q   <= frame_len_d;
      last_grant_q  <= last_grant_d;
      occ_q         <= occ_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
    end
  end

  assign o_ppfifo_act = act_q;
  assign o_axi_valid  = (occ_q != 2'd0);
  assign o_axi_data   = ent0_q.data;
  assign o_axi_keep   = ent0_q.keep;
  assign o_axi_last   = ent0_q.last;
  assign o_axi_user   = ent0_q.user;
  assign o_axi_dest   = ent0_q.dest;

endmodule

// File: tb/tb_adapter_ppfifo_2_axi_stream_mc.sv
// Scoreboard bench for the multi-channel ppfifo to AXI Stream adapter.
// A behavioural model turns queued blocks into the expected beat stream;
// a FIFO model serves the read ports and a monitor checks every AXI transfer.
module tb_adapter_ppfifo_2_axi_stream_mc;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int SW = 4;
  localparam int CH = 2;
  localparam int CB = 1;
  localparam int WW = DW + UW;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     i_ppfifo_rdy;
  logic [CH-1:0]     o_ppfifo_act;
  logic [CH*24-1:0]  i_ppfifo_size;
  logic [CH*WW-1:0]  i_ppfifo_data;
  logic [CH-1:0]     o_ppfifo_stb;
  logic [23:0]       i_total_out_size;
  logic [SW-1:0]     i_last_keep;
  logic              o_axi_valid;
  logic              i_axi_ready;
  logic [DW-1:0]     o_axi_data;
  logic [SW-1:0]     o_axi_keep;
  logic              o_axi_last;
  logic [UW-1:0]     o_axi_user;
  logic [CB-1:0]     o_axi_dest;

  adapter_ppfifo_2_axi_stream_mc #(
    .DATA_WIDTH  (DW),
    .STROBE_WIDTH(SW),
    .USER_WIDTH  (UW),
    .CHANNELS    (CH),
    .CHANNEL_BITS(CB)
  ) dut (
    .i_axi_clk       (clk),
    .rst             (rst),
    .i_ppfifo_rdy    (i_ppfifo_rdy),
    .o_ppfifo_act    (o_ppfifo_act),
    .i_ppfifo_size   (i_ppfifo_size),
    .i_ppfifo_data   (i_ppfifo_data),
    .o_ppfifo_stb    (o_ppfifo_stb),
    .i_total_out_size(i_total_out_size),
    .i_last_keep     (i_last_keep),
    .o_axi_valid     (o_axi_valid),
    .i_axi_ready     (i_axi_ready),
    .o_axi_data      (o_axi_data),
    .o_axi_keep      (o_axi_keep),
    .o_axi_last      (o_axi_last),
    .o_axi_user      (o_axi_user),
    .o_axi_dest      (o_axi_dest)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO-side contents (served to the DUT) and model-side copies.
  logic [WW-1:0] fifo_words[CH][$];
  int            fifo_sizes[CH][$];
  logic [WW-1:0] m_words[CH][$];
  int            m_sizes[CH][$];
  logic [63:0]   exp_q[$];

  int m_last = CH - 1;
  int m_fc   = 0;
  int m_flen = 0;

  int stb_total    = 0;
  int beats_seen   = 0;
  int rdy_rise_cyc = -1;
  int act_rise_cyc = -1;
  int val_rise_cyc = -1;
  bit rand_ready   = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dut_beat();
    return {22'b0, o_axi_data, o_axi_user, o_axi_keep, o_axi_last, o_axi_dest};
  endfunction

  task automatic load_block(input int ch, input int size);
    logic [WW-1:0] w;
    fifo_sizes[ch].push_back(size);
    m_sizes[ch].push_back(size);
    for (int k = 0; k < size; k++) begin
      w[DW-1:0]  = $urandom;
      w[WW-1:DW] = UW'($urandom_range(0, 15));
      fifo_words[ch].push_back(w);
      m_words[ch].push_back(w);
    end
  endtask

  // Expected stream from the rules: round-robin over channels holding blocks,
  // a partly sent frame keeps its channel, TLAST by block end or frame length.
  task automatic model_run(input int total, input logic [SW-1:0] lk);
    int ch;
    int c;
    int size;
    logic lst;
    logic [WW-1:0] w;
    for (int guard = 0; guard < 64; guard++) begin
      ch = -1;
      if (m_fc != 0) begin
        if (m_sizes[m_last].size() > 0) ch = m_last;
      end else begin
        for (int i = 1; i <= CH; i++) begin
          c = (m_last + i) % CH;
          if (ch < 0 && m_sizes[c].size() > 0) ch = c;
        end
      end
      if (ch < 0) break;
      size   = m_sizes[ch].pop_front();
      m_last = ch;
      if (m_fc == 0) m_flen = total;
      for (int k = 0; k < size; k++) begin
        w    = m_words[ch].pop_front();
        lst  = (m_flen == 0) ? (k == size - 1) : (m_fc + 1 == m_flen);
        m_fc = lst ? 0 : m_fc + 1;
        exp_q.push_back({22'b0, w[DW-1:0], w[WW-1:DW], (lst ? lk : 4'hf), lst, CB'(ch)});
      end
    end
  endtask

  // Ping-pong FIFO read-port model. A strobe seen at one negedge is consumed
  // by the following posedge, so the word pops at the next negedge.
  initial begin
    bit       stb_prev[CH];
    bit       act_prev[CH];
    int       cur_left[CH];
    int       blk_size[CH];
    int       act_len[CH];
    bit       nrdy;
    for (int c = 0; c < CH; c++) begin
      stb_prev[c] = 0; act_prev[c] = 0; cur_left[c] = 0; blk_size[c] = 0; act_len[c] = 0;
    end
    i_ppfifo_rdy  = '0;
    i_ppfifo_size = '0;
    i_ppfifo_data = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (stb_prev[c]) begin
          stb_total++;
          if (fifo_words[c].size() > 0) void'(fifo_words[c].pop_front());
          if (cur_left[c] > 0) cur_left[c]--;
        end
        if (o_ppfifo_act[c] && !act_prev[c]) begin
          cur_left[c] = (fifo_sizes[c].size() > 0) ? fifo_sizes[c][0] : 0;
          blk_size[c] = cur_left[c];
          act_len[c]  = 0;
          if (act_rise_cyc < 0) act_rise_cyc = cyc;
        end
        if (o_ppfifo_act[c]) act_len[c]++;
        if (!o_ppfifo_act[c] && act_prev[c]) begin
          if (!rst) begin
            check("block_drained", 64'(cur_left[c]), 64'd0);
            if (blk_size[c] == 0) check("zero_block_act_len", 64'(act_len[c]), 64'd1);
          end
          while (cur_left[c] > 0) begin
            if (fifo_words[c].size() > 0) void'(fifo_words[c].pop_front());
            cur_left[c]--;
          end
          if (fifo_sizes[c].size() > 0) void'(fifo_sizes[c].pop_front());
        end
        if (o_ppfifo_stb[c] && !rst)
          check("stb_in_block", 64'(o_ppfifo_act[c] && (cur_left[c] > 0)), 64'd1);
        stb_prev[c] = o_ppfifo_stb[c];
        act_prev[c] = o_ppfifo_act[c];
        nrdy = (fifo_sizes[c].size() > 0) && !o_ppfifo_act[c];
        if (nrdy && !i_ppfifo_rdy[c] && rdy_rise_cyc < 0) rdy_rise_cyc = cyc;
        i_ppfifo_rdy[c] = nrdy;
        i_ppfifo_size[c*24 +: 24] = (fifo_sizes[c].size() > 0) ? 24'(fifo_sizes[c][0]) : 24'd0;
        i_ppfifo_data[c*WW +: WW] = (fifo_words[c].size() > 0) ? fifo_words[c][0] : '0;
      end
    end
  end

  // AXI sink: drives TREADY, checks held beats and pops the scoreboard.
  initial begin
    bit          hold;
    logic [63:0] held;
    bit          r;
    hold        = 0;
    held        = '0;
    i_axi_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("valid_held", 64'(o_axi_valid), 64'd1);
          check("beat_held", dut_beat(), held);
        end
        r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        i_axi_ready = r;
        if (o_axi_valid && val_rise_cyc < 0) val_rise_cyc = cyc;
        if (o_axi_valid && r) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got %h, expected no beat", dut_beat());
          end else begin
            check("beat", dut_beat(), exp_q.pop_front());
          end
          beats_seen++;
        end
        hold = o_axi_valid && !r;
        held = dut_beat();
      end
    end
  end

  task automatic check_reset_values();
    check("rst_act", 64'(o_ppfifo_act), 64'd0);
    check("rst_stb", 64'(o_ppfifo_stb), 64'd0);
    check("rst_valid", 64'(o_axi_valid), 64'd0);
    check("rst_data", 64'(o_axi_data), 64'd0);
    check("rst_keep", 64'(o_axi_keep), 64'd0);
    check("rst_last", 64'(o_axi_last), 64'd0);
    check("rst_user", 64'(o_axi_user), 64'd0);
    check("rst_dest", 64'(o_axi_dest), 64'd0);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || fifo_sizes[0].size() != 0 || fifo_sizes[1].size() != 0)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_in_budget", 64'(k < budget), 64'd1);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int s0;
    int b0;
    int k;
    rst              = 1'b1;
    i_total_out_size = 24'd0;
    i_last_keep      = 4'hf;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1 rst = 1'b0;

    // Two blocks, per-block TLAST, plus grant-to-valid latency.
    @(posedge clk); #1;
    i_total_out_size = 24'd0;
    i_last_keep      = 4'h7;
    rdy_rise_cyc = -1; act_rise_cyc = -1; val_rise_cyc = -1;
    load_block(0, 4);
    load_block(1, 3);
    model_run(0, 4'h7);
    drain(200);
    check("lat_act", 64'(act_rise_cyc - rdy_rise_cyc), 64'd1);
    check("lat_valid", 64'(val_rise_cyc - rdy_rise_cyc), 64'd2);

    // Frame length 6 across blocks of 4: channel 1 waits on the lock.
    @(posedge clk); #1;
    i_total_out_size = 24'd6;
    i_last_keep      = 4'h1;
    load_block(0, 4);
    load_block(0, 4);
    load_block(0, 4);
    load_block(1, 6);
    model_run(6, 4'h1);
    drain(300);

    // Long block under random backpressure.
    @(posedge clk); #1;
    i_total_out_size = 24'd0;
    i_last_keep      = 4'hc;
    rand_ready       = 1'b1;
    s0 = stb_total;
    load_block(0, 64);
    model_run(0, 4'hc);
    drain(1500);
    check("stb_count_64", 64'(stb_total - s0), 64'd64);
    @(posedge clk); #1 rand_ready = 1'b0;

    // Zero-size block on channel 1, then a normal block on channel 0.
    @(posedge clk); #1;
    b0 = beats_seen;
    s0 = stb_total;
    load_block(1, 0);
    model_run(0, 4'hc);
    drain(100);
    check("zero_block_beats", 64'(beats_seen - b0), 64'd0);
    check("zero_block_stbs", 64'(stb_total - s0), 64'd0);
    @(posedge clk); #1;
    load_block(0, 3);
    model_run(0, 4'hc);
    drain(100);

    // Reset in the middle of an 8-word block.
    @(posedge clk); #1;
    b0 = beats_seen;
    load_block(0, 8);
    model_run(0, 4'hc);
    k = 0;
    while (beats_seen < b0 + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("mid_block_beats_seen", 64'(beats_seen >= b0 + 2), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      m_sizes[c].delete();
      m_words[c].delete();
    end
    m_last = CH - 1;
    m_fc   = 0;
    m_flen = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    load_block(1, 2);
    load_block(0, 2);
    model_run(0, 4'hc);
    drain(200);

    // Frame length 1: every beat is a TLAST beat.
    @(posedge clk); #1;
    i_total_out_size = 24'd1;
    i_last_keep      = 4'h3;
    load_block(0, 3);
    load_block(1, 2);
    model_run(1, 4'h3);
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
